// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle for the memory responder.
// 64b address, 512b data, 64b strobe, 16b id.
interface axi_bus_t;
    logic [63:0]  araddr;
    logic [15:0]  arid;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;

    logic [511:0] rdata;
    logic [15:0]  rid;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    logic [63:0]  awaddr;
    logic [15:0]  awid;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;

    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;

    logic [15:0]  bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    modport master (
        input  araddr, arid, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rid, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awid, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport slave (
        output araddr, arid, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rid, rresp, rlast, rvalid,
        output rready,
        output awaddr, awid, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a 512-bit line memory,
// with burst and error statistics on a softreg port.
package axi_mem_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;
endpackage

module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned BURST_MAX  = 64
) (
    input  logic       clk,
    input  logic       rst,
    axi_bus_t.master   axi_s,
    input  SoftRegReq  softreg_req,
    output SoftRegResp softreg_resp
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    logic [511:0] mem [DEPTH];

    r_state_t     r_state;
    idx_t         r_idx;
    logic [7:0]   r_len;
    logic [8:0]   r_issued;
    logic         r_err;
    logic [15:0]  r_id;
    logic         arready_q;
    logic         rvalid_q;
    logic         rlast_q;
    logic [511:0] rdata_q;
    logic         r_fetch;
    logic         r_take;

    w_state_t     w_state;
    idx_t         w_idx;
    logic [7:0]   w_len;
    logic [7:0]   w_cnt;
    logic         w_err;
    logic [15:0]  w_id;
    logic         awready_q;
    logic         wready_q;
    logic         bvalid_q;
    logic [1:0]   bresp_q;
    logic         w_take;
    logic         w_final;

    logic [63:0]  cnt_rd;
    logic [63:0]  cnt_wr;
    logic [63:0]  cnt_err;
    logic         rd_done;
    logic         wr_done;
    logic         rd_slverr;
    logic         wr_slverr;
    logic         sr_clear;
    logic         resp_valid;
    logic [63:0]  resp_data;

    // A beat is fetched whenever the output register is free or draining.
    assign r_take  = rvalid_q && axi_s.rready;
    assign r_fetch = (r_state == R_BURST)
                  && (r_issued <= {1'b0, r_len})
                  && (!rvalid_q || axi_s.rready);

    assign w_take  = wready_q && axi_s.wvalid && !rst;
    assign w_final = (w_cnt == w_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (axi_s.arvalid && arready_q) begin
                        r_state   <= R_BURST;
                        arready_q <= 1'b0;
                        r_id      <= axi_s.arid;
                        r_idx     <= axi_s.araddr[6 +: DEPTH_LOG2];
                        r_len     <= axi_s.arlen;
                        r_issued  <= '0;
                        r_err     <= 32'(axi_s.arlen) >= BURST_MAX;
                    end
                end
                R_BURST: begin
                    if (r_fetch) begin
                        rvalid_q <= 1'b1;
                        rlast_q  <= (r_issued[7:0] == r_len);
                        r_idx    <= r_idx + idx_t'(1);
                        r_issued <= r_issued + 9'd1;
                    end else if (r_take) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            r_state   <= R_IDLE;
                            arready_q <= 1'b1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_fetch) begin
            rdata_q <= mem[r_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            for (int b = 0; b < 64; b++) begin
                if (axi_s.wstrb[b]) begin
                    mem[w_idx][8*b +: 8] <= axi_s.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'd0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (axi_s.awvalid && awready_q) begin
                        w_state   <= W_DATA;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_id      <= axi_s.awid;
                        w_idx     <= axi_s.awaddr[6 +: DEPTH_LOG2];
                        w_len     <= axi_s.awlen;
                        w_cnt     <= '0;
                        w_err     <= 32'(axi_s.awlen) >= BURST_MAX;
                    end
                end
                W_DATA: begin
                    if (w_take) begin
                        w_idx <= w_idx + idx_t'(1);
                        w_cnt <= w_cnt + 8'd1;
                        // Either the counted end or an early wlast closes the burst.
                        if (w_final || axi_s.wlast) begin
                            w_state  <= W_RESP;
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (w_err || (axi_s.wlast != w_final))
                                      ? 2'd2 : 2'd0;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_q && axi_s.bready) begin
                        bvalid_q  <= 1'b0;
                        w_state   <= W_IDLE;
                        awready_q <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign axi_s.arready = arready_q;
    assign axi_s.rvalid  = rvalid_q;
    assign axi_s.rlast   = rlast_q;
    assign axi_s.rdata   = rdata_q;
    assign axi_s.rid     = r_id;
    assign axi_s.rresp   = r_err ? 2'd2 : 2'd0;
    assign axi_s.awready = awready_q;
    assign axi_s.wready  = wready_q;
    assign axi_s.bvalid  = bvalid_q;
    assign axi_s.bid     = w_id;
    assign axi_s.bresp   = bresp_q;

    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [1:0]  n
    );
        logic [64:0] s;
        s = {1'b0, a} + {63'd0, n};
        return s[64] ? '1 : s[63:0];
    endfunction

    assign rd_done   = r_take && rlast_q;
    assign wr_done   = bvalid_q && axi_s.bready;
    assign rd_slverr = rd_done && r_err;
    assign wr_slverr = wr_done && (bresp_q == 2'd2);
    assign sr_clear  = softreg_req.valid && softreg_req.is_write;

    always_ff @(posedge clk) begin
        if (rst || sr_clear) begin
            cnt_rd  <= '0;
            cnt_wr  <= '0;
            cnt_err <= '0;
        end else begin
            cnt_rd  <= sat_add(cnt_rd, {1'b0, rd_done});
            cnt_wr  <= sat_add(cnt_wr, {1'b0, wr_done});
            cnt_err <= sat_add(cnt_err,
                               {1'b0, rd_slverr} + {1'b0, wr_slverr});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= softreg_req.valid && !softreg_req.is_write;
            case (softreg_req.addr)
                32'h0:   resp_data <= cnt_rd;
                32'h8:   resp_data <= cnt_wr;
                32'h10:  resp_data <= cnt_err;
                default: resp_data <= '0;
            endcase
        end
    end

    assign softreg_resp.valid = resp_valid;
    assign softreg_resp.data  = resp_data;

    logic unused_fields;
    assign unused_fields = ^{
        axi_s.araddr[63:6+DEPTH_LOG2], axi_s.araddr[5:0],
        axi_s.awaddr[63:6+DEPTH_LOG2], axi_s.awaddr[5:0],
        axi_s.arsize, axi_s.arburst,
        axi_s.awsize, axi_s.awburst,
        softreg_req.data
    };
endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder against
// a line-array memory model and counter model.
module tb_axi_mem_responder;
    import axi_mem_pkg::*;

    localparam int DL    = 6;
    localparam int DEPTH = 1 << DL;
    localparam int BMAX  = 64;

    logic       clk = 1'b0;
    logic       rst;
    SoftRegReq  sr_req;
    SoftRegResp sr_resp;

    always #5 clk = ~clk;

    axi_bus_t axi();

    axi_mem_responder #(
        .DEPTH_LOG2(DL),
        .BURST_MAX (BMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_s       (axi),
        .softreg_req (sr_req),
        .softreg_resp(sr_resp)
    );

    logic [511:0] model [DEPTH];
    logic [63:0]  m_rd;
    logic [63:0]  m_wr;
    logic [63:0]  m_err;
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string tag,
                         input logic [511:0] got,
                         input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic int line_of(input logic [63:0] addr);
        return int'(addr[6 +: DL]);
    endfunction

    task automatic axi_write(input logic [63:0] addr, input int len,
                             input int wlast_at, input logic [63:0] strb);
        int           beats, idx, g, b, line;
        logic [15:0]  id;
        logic [1:0]   exp_resp;
        logic [511:0] d;
        beats    = ((wlast_at < len) ? wlast_at : len) + 1;
        idx      = line_of(addr);
        id       = 16'($urandom);
        exp_resp = (wlast_at != len || len >= BMAX) ? 2'd2 : 2'd0;
        @(negedge clk);
        axi.awaddr  = addr;
        axi.awlen   = 8'(len);
        axi.awid    = id;
        axi.awsize  = 3'd6;
        axi.awburst = 2'd1;
        axi.awvalid = 1'b1;
        g = 0;
        while (!axi.awready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("aw_ready", 512'(axi.awready), 512'(1));
        @(negedge clk);
        axi.awvalid = 1'b0;
        b = 0;
        g = 0;
        while (b < beats && g < 1000) begin
            if ($urandom_range(3) == 0) begin
                axi.wvalid = 1'b0;
                @(negedge clk);
                g++;
            end
            d          = rand_line();
            axi.wvalid = 1'b1;
            axi.wdata  = d;
            axi.wstrb  = strb;
            axi.wlast  = (b == wlast_at);
            while (!axi.wready && g < 1000) begin
                @(negedge clk);
                g++;
            end
            if (axi.wready) begin
                line = (idx + b) % DEPTH;
                for (int k = 0; k < 64; k++)
                    if (strb[k]) model[line][8*k +: 8] = d[8*k +: 8];
                b++;
            end
            @(negedge clk);
            g++;
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        check("w_beats", 512'(b), 512'(beats));
        check("w_closed", 512'(axi.wready), 512'(0));
        g = 0;
        while (!axi.bvalid && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("b_valid", 512'(axi.bvalid), 512'(1));
        if ($urandom_range(1) == 1) begin
            @(negedge clk);
            check("b_hold", 512'(axi.bvalid), 512'(1));
        end
        check("bid", 512'(axi.bid), 512'(id));
        check("bresp", 512'(axi.bresp), 512'(exp_resp));
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("b_done", 512'(axi.bvalid), 512'(0));
        m_wr++;
        if (exp_resp == 2'd2) m_err++;
    endtask

    // mode 0: rready always high, 1: toggles, 2: random
    task automatic axi_read(input logic [63:0] addr, input int len,
                            input int mode);
        int           idx, b, g, lat, first;
        logic [15:0]  id;
        logic [1:0]   exp_resp;
        logic         stalled;
        logic [511:0] held;
        idx      = line_of(addr);
        id       = 16'($urandom);
        exp_resp = (len >= BMAX) ? 2'd2 : 2'd0;
        @(negedge clk);
        axi.araddr  = addr;
        axi.arlen   = 8'(len);
        axi.arid    = id;
        axi.arsize  = 3'd6;
        axi.arburst = 2'd1;
        axi.arvalid = 1'b1;
        g = 0;
        while (!axi.arready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("ar_ready", 512'(axi.arready), 512'(1));
        @(negedge clk);
        axi.arvalid = 1'b0;
        lat     = 1;
        first   = -1;
        b       = 0;
        g       = 0;
        stalled = 1'b0;
        held    = '0;
        while (b <= len && g < 2000) begin
            if (first < 0 && axi.rvalid) first = lat;
            if (stalled) check("r_stable", axi.rdata, held);
            case (mode)
                0:       axi.rready = 1'b1;
                1:       axi.rready = (g % 2 == 0);
                default: axi.rready = 1'($urandom_range(1));
            endcase
            stalled = axi.rvalid && !axi.rready;
            held    = axi.rdata;
            if (axi.rvalid && axi.rready) begin
                check("rdata", axi.rdata, model[(idx + b) % DEPTH]);
                check("rlast", 512'(axi.rlast), 512'(b == len));
                check("rresp", 512'(axi.rresp), 512'(exp_resp));
                check("rid", 512'(axi.rid), 512'(id));
                b++;
            end
            @(negedge clk);
            g++;
            lat++;
        end
        axi.rready = 1'b0;
        check("r_beats", 512'(b), 512'(len + 1));
        check("r_latency", 512'(first), 512'(2));
        check("ar_ready_back", 512'(axi.arready), 512'(1));
        m_rd++;
        if (exp_resp == 2'd2) m_err++;
    endtask

    task automatic sr_read(input logic [31:0] a, input logic [63:0] exp,
                           input string tag);
        @(negedge clk);
        sr_req.valid    = 1'b1;
        sr_req.is_write = 1'b0;
        sr_req.addr     = a;
        sr_req.data     = 64'($urandom);
        @(negedge clk);
        sr_req.valid = 1'b0;
        check({tag, "_valid"}, 512'(sr_resp.valid), 512'(1));
        check(tag, 512'(sr_resp.data), 512'(exp));
    endtask

    task automatic sr_clear();
        @(negedge clk);
        sr_req.valid    = 1'b1;
        sr_req.is_write = 1'b1;
        sr_req.addr     = 32'($urandom);
        sr_req.data     = 64'($urandom);
        @(negedge clk);
        sr_req.valid = 1'b0;
        check("sr_wr_noresp", 512'(sr_resp.valid), 512'(0));
        m_rd  = '0;
        m_wr  = '0;
        m_err = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] a;
        int          len, wl, g;
        m_rd  = '0;
        m_wr  = '0;
        m_err = '0;
        sr_req      = '0;
        axi.araddr  = '0;
        axi.arid    = '0;
        axi.arlen   = '0;
        axi.arsize  = '0;
        axi.arburst = '0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awaddr  = '0;
        axi.awid    = '0;
        axi.awlen   = '0;
        axi.awsize  = '0;
        axi.awburst = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.wlast   = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_arready", 512'(axi.arready), 512'(0));
        check("rst_awready", 512'(axi.awready), 512'(0));
        check("rst_wready", 512'(axi.wready), 512'(0));
        check("rst_rvalid", 512'(axi.rvalid), 512'(0));
        check("rst_rlast", 512'(axi.rlast), 512'(0));
        check("rst_bvalid", 512'(axi.bvalid), 512'(0));
        check("rst_sr_valid", 512'(sr_resp.valid), 512'(0));
        rst = 1'b0;
        @(negedge clk);
        check("arready_up", 512'(axi.arready), 512'(1));
        check("awready_up", 512'(axi.awready), 512'(1));
        sr_read(32'h0, 64'd0, "sr_rd_init");

        axi_write(64'h0, DEPTH - 1, DEPTH - 1, '1);

        axi_write(64'h40, 3, 3, '1);
        axi_read(64'h40, 3, 0);

        axi_read({$urandom, $urandom}, 7, 1);

        a = {$urandom, $urandom};
        axi_write(a, 0, 0, 64'hFF);
        axi_read(a, 0, 0);

        axi_write(64'(DEPTH - 1) << 6, 1, 1, '1);
        axi_read(64'(DEPTH - 1) << 6, 1, 0);
        axi_read(64'h0, 0, 0);

        sr_clear();
        axi_write(64'h200, 3, 1, '1);
        sr_read(32'h10, 64'd1, "sr_err_early_wlast");
        sr_read(32'h8, 64'd1, "sr_wr_cnt");
        sr_read(32'h0, 64'd0, "sr_rd_cnt");

        axi_write(64'h300, 5, 100, '1);
        axi_write(64'h0, BMAX, BMAX, {$urandom, $urandom});
        axi_read(64'h80, BMAX + 6, 2);

        fork
            axi_write(64'h0, 7, 7, {$urandom, $urandom});
            axi_read(64'(32) << 6, 7, 2);
        join

        for (int i = 0; i < 40; i++) begin
            a   = {$urandom, $urandom};
            len = $urandom_range(15);
            if ($urandom_range(1) == 1) begin
                wl = ($urandom_range(4) == 0) ? $urandom_range(len + 2) : len;
                axi_write(a, len, wl, {$urandom, $urandom});
            end else begin
                axi_read(a, len, $urandom_range(2));
            end
        end

        sr_read(32'h0, m_rd, "sr_rd_total");
        sr_read(32'h8, m_wr, "sr_wr_total");
        sr_read(32'h10, m_err, "sr_err_total");
        sr_read(32'h18, 64'd0, "sr_other");

        @(negedge clk);
        axi.araddr  = 64'h400;
        axi.arlen   = 8'd7;
        axi.arid    = 16'h5a5a;
        axi.arvalid = 1'b1;
        g = 0;
        while (!axi.arready && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rvalid", 512'(axi.rvalid), 512'(1));
        rst = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        check("rst_mid_rvalid", 512'(axi.rvalid), 512'(0));
        check("rst_mid_arready", 512'(axi.arready), 512'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_rel_arready", 512'(axi.arready), 512'(1));
        check("rst_rel_awready", 512'(axi.awready), 512'(1));
        m_rd  = '0;
        m_wr  = '0;
        m_err = '0;
        sr_read(32'h0, 64'd0, "sr_rd_after_rst");
        axi_read({$urandom, $urandom}, 15, 2);
        axi_read(64'h40, 3, 0);
        sr_read(32'h0, m_rd, "sr_rd_post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001: The module SHALL have parameter DEPTH_LOG2, default 10, giving the log2 of the number of 512-bit memory lines.
REQ-002: The module SHALL have parameter BURST_MAX, default 64, giving the maximum beats per burst; arlen/awlen values at or above BURST_MAX are errors.
REQ-003: Port clk  input  1  is the sole clock; all logic is on its rising edge.
REQ-004: Port rst  input  1  is the reset, synchronous and active-high.
REQ-005: Port axi_s  axi_bus_t.master  bundle  is the AXI4 slave-side endpoint: it receives AR/AW/W and drives R/B; 64b addr, 512b data, 64b strobe, 16b id.
REQ-006: Port softreg_req  input  SoftRegReq  is the statistics register request.
REQ-007: Port softreg_resp  output  SoftRegResp  is the statistics register response.

Function
REQ-008: Storage SHALL be 2^DEPTH_LOG2 lines; line index = addr[6+DEPTH_LOG2-1:6]; upper bits ignored; index wraps modulo depth within a burst.
REQ-009: Only INCR, size 6 (64 B) bursts SHALL be supported; burst/size fields are otherwise ignored.
REQ-010: The read FSM SHALL have states R_IDLE and R_BURST; arready=1 only in R_IDLE; AR handshake latches id, index, len and enters R_BURST.
REQ-011: In R_BURST the FSM SHALL present one beat per cycle while rready=1; rvalid first rises 2 cycles after the AR handshake (registered memory read).
REQ-012: rdata/rid/rlast/rresp SHALL hold stable while rvalid=1 and rready=0, with no beat lost or duplicated.
REQ-013: rlast SHALL be 1 exactly on beat len; after its handshake the FSM returns to R_IDLE, and arready is 1 in the following cycle.
REQ-014: The write FSM SHALL have states W_IDLE, W_DATA and W_RESP; awready=1 only in W_IDLE; AW handshake latches id, index, len.
REQ-015: wready SHALL be 1 only in W_DATA; each W handshake writes the bytes selected by wstrb to the current line and increments the index.
REQ-016: A W handshake whose beat count reaches len+1 SHALL move to W_RESP regardless of wlast; wlast=1 on an earlier beat also moves to W_RESP.
REQ-017: In W_RESP, bvalid=1 and bid=latched id, held until bready; then return to W_IDLE.
REQ-018: bresp SHALL be OKAY(0) except SLVERR(2) when wlast mismatched the expected final beat or len>=BURST_MAX.
REQ-019: rresp SHALL be SLVERR(2) on all beats when len>=BURST_MAX; data is still returned.
REQ-020: Read and write FSMs SHALL operate concurrently.
REQ-021: A W write in cycle N SHALL be visible to a memory read issued in cycle N+1 or later; a same-cycle same-line read returns the old data.
REQ-022: Softreg reads SHALL return their value with softreg_resp.valid=1 exactly 1 cycle after the request.
REQ-023: Softreg read addr 0x0 SHALL return 64b completed read-burst count; 0x8 completed write-burst count; 0x10 SLVERR count; other addrs return 0.
REQ-024: A softreg write to any address SHALL clear all three counters in the next cycle; it produces no response.
REQ-025: Counters SHALL saturate at 2^64-1.

Reset
REQ-026: While rst=1: FSMs to R_IDLE/W_IDLE; arready, awready, wready, rvalid, bvalid, rlast, softreg_resp.valid = 0; counters = 0.
REQ-027: rst asserted mid-burst SHALL abandon the burst with no B/R completion; memory contents are retained (not cleared).
REQ-028: arready and awready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-029: The bench SHALL cover: AW addr 0x40 len 3, 4 beats with full strobe and data k, then AR 0x40 len 3 -> R beats k0..k3, rlast on beat 3, bresp=0, rresp=0.
REQ-030: The bench SHALL cover: read len 7 with rready toggling 1/0 each cycle -> 8 beats in order, data stable during stalls, rlast only on beat 7.
REQ-031: The bench SHALL cover: write with wstrb=0x00..0FF over existing data -> only bytes 0-7 change on readback.
REQ-032: The bench SHALL cover: write at the last line, len 1 -> second beat lands at line 0 (wrap).
REQ-033: The bench SHALL cover: write len 3 with wlast on beat 1 -> B after 2 beats with bresp=2; softreg 0x10 reads 1.
REQ-034: The bench SHALL cover: rst mid read burst -> rvalid=0 next cycle, arready=1 after release; softreg 0x0 reads 0.
